pc_unit: RTL

- Parametrised program-counter unit for the pipelined core. Successor to the fixed 16-bit enable-only PC register.
- Holds the fetch PC and selects the next PC each cycle, in priority order: redirect, halt, stall, return, call, sequential.
- Contains a small circular return-address stack (RAS) and a RUN/HALTED state machine.
- Sits between the fetch stage and the decode/execute redirect logic.

---
 rtl/pc_pkg.sv | 17 +
 rtl/pc_if.sv | 30 +++
 rtl/pc_ras.sv | 53 +++++
 rtl/pc_unit.sv | 113 +++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared types for the program-counter unit
package pc_pkg;

    typedef enum logic {
        PC_RUN    = 1'b0,
        PC_HALTED = 1'b1
    } pc_state_e;

    typedef enum logic [2:0] {
        SRC_REDIR,
        SRC_HOLD,
        SRC_RET,
        SRC_CALL,
        SRC_SEQ
    } pc_src_e;

endpackage

// File: rtl/pc_if.sv
// rtl/pc_if.sv - fetch/redirect control bundle between the pipeline and the PC unit
interface pc_if #(
    parameter int WIDTH = 16
);
    logic             stall;
    logic             halt;
    logic             redirect_valid;
    logic [WIDTH-1:0] redirect_target;
    logic             call_valid;
    logic [WIDTH-1:0] call_target;
    logic             ret_valid;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_plus;
    logic             halted;
    logic             ras_empty;
    logic             ras_full;
    logic             ras_underflow;

    modport master (
        output stall, halt, redirect_valid, redirect_target,
               call_valid, call_target, ret_valid,
        input  pc, pc_plus, halted, ras_empty, ras_full, ras_underflow
    );

    modport slave (
        input  stall, halt, redirect_valid, redirect_target,
               call_valid, call_target, ret_valid,
        output pc, pc_plus, halted, ras_empty, ras_full, ras_underflow
    );
endinterface

// File: rtl/pc_ras.sv
// rtl/pc_ras.sv - circular return-address stack, oldest entry overwritten when full
module pc_ras #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top_data,
    output logic             empty,
    output logic             full
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    top_ptr;
    logic [CW-1:0]    count;
    logic             do_pop;
    logic             do_push;

    assign do_pop  = pop && !empty;
    assign do_push = push && !pop;

    // top_ptr addresses the newest entry; a push on a full stack lands on the oldest slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            top_ptr <= '0;
            count   <= '0;
        end else if (do_pop) begin
            top_ptr <= top_ptr - PW'(1);
            count   <= count - CW'(1);
        end else if (do_push) begin
            top_ptr <= top_ptr + PW'(1);
            if (!full) begin
                count <= count + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[top_ptr + PW'(1)] <= push_data;
        end
    end

    assign top_data = mem[top_ptr];
    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));

endmodule

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - fetch PC register with priority next-PC select, RAS and RUN/HALTED control
module pc_unit
    import pc_pkg::*;
#(
    parameter int               WIDTH     = 16,
    parameter int               INC       = 2,
    parameter logic [WIDTH-1:0] RESET_VEC = '0,
    parameter int               RAS_DEPTH = 4
) (
    input logic  clk,
    input logic  rst_n,
    pc_if.slave  bus
);
    localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);

    pc_state_e        state_q, state_d;
    pc_src_e          src;
    logic [WIDTH-1:0] pc_q, pc_d, pc_plus, ras_top;
    logic             ras_push, ras_pop, ras_empty, ras_full;
    logic             underflow_q, underflow_set;

    assign pc_plus = pc_q + INC_W;

    pc_ras #(
        .WIDTH (WIDTH),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (pc_plus),
        .top_data  (ras_top),
        .empty     (ras_empty),
        .full      (ras_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= PC_RUN;
            pc_q        <= RESET_VEC;
            underflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if (underflow_set) begin
                underflow_q <= 1'b1;
            end
        end
    end

    // HALTED only listens to redirect; in RUN the if-chain order is the selection priority
    always_comb begin
        state_d       = state_q;
        src           = SRC_SEQ;
        ras_push      = 1'b0;
        ras_pop       = 1'b0;
        underflow_set = 1'b0;
        unique case (state_q)
            PC_HALTED: begin
                if (bus.redirect_valid) begin
                    src     = SRC_REDIR;
                    state_d = PC_RUN;
                end else begin
                    src = SRC_HOLD;
                end
            end
            default: begin
                if (bus.redirect_valid) begin
                    src = SRC_REDIR;
                end else if (bus.halt) begin
                    src     = SRC_HOLD;
                    state_d = PC_HALTED;
                end else if (bus.stall) begin
                    src = SRC_HOLD;
                end else if (bus.ret_valid) begin
                    if (!ras_empty) begin
                        src     = SRC_RET;
                        ras_pop = 1'b1;
                    end else begin
                        src           = SRC_SEQ;
                        underflow_set = 1'b1;
                    end
                end else if (bus.call_valid) begin
                    src      = SRC_CALL;
                    ras_push = 1'b1;
                end else begin
                    src = SRC_SEQ;
                end
            end
        endcase
    end

    always_comb begin
        pc_d = pc_q;
        case (src)
            SRC_REDIR: pc_d = bus.redirect_target;
            SRC_HOLD:  pc_d = pc_q;
            SRC_RET:   pc_d = ras_top;
            SRC_CALL:  pc_d = bus.call_target;
            SRC_SEQ:   pc_d = pc_plus;
            default:   pc_d = pc_q;
        endcase
    end

    assign bus.pc            = rst_n ? pc_q : RESET_VEC;
    assign bus.pc_plus       = pc_plus;
    assign bus.halted        = (state_q == PC_HALTED);
    assign bus.ras_empty     = ras_empty;
    assign bus.ras_full      = ras_full;
    assign bus.ras_underflow = underflow_q;

endmodule
